bullet_scheduler: RTL and testbench

//  Owns a pool of NUM_BULLETS bullet slots (position, direction, alive) and sequences them:

---
 rtl/bullet_scheduler.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_bullet_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_scheduler.sv
// Bullet slot pool: allocates slots on fire, steps live slots on each movement
// tick, retires hit or off-screen slots, and time-shares one pixel-plot port.
module bullet_scheduler #(
  parameter int NUM_BULLETS = 4,
  parameter int TICK_DIV    = 12500000,
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 119
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fire,
  input  logic [7:0]             ship_x,
  input  logic [6:0]             ship_y,
  input  logic [1:0]             dir_x,
  input  logic [1:0]             dir_y,
  input  logic [NUM_BULLETS-1:0] hit,
  input  logic                   plot_ready,
  output logic                   plot,
  output logic [7:0]             plot_x,
  output logic [6:0]             plot_y,
  output logic [2:0]             plot_colour,
  output logic [NUM_BULLETS-1:0] active,
  output logic                   fire_ack,
  output logic                   fire_drop
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam logic [7:0] XM = 8'(X_MAX);
  localparam logic [6:0] YM = 7'(Y_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALLOC = 3'd1,
    S_SPAWN = 3'd2,
    S_SCAN  = 3'd3,
    S_ERASE = 3'd4,
    S_MOVE  = 3'd5,
    S_DRAW  = 3'd6
  } state_t;

  // Direction code 11 is meaningless and behaves as hold.
  function automatic logic [1:0] eff_dir(input logic [1:0] d);
    eff_dir = (d == 2'b11) ? 2'b00 : d;
  endfunction

  function automatic logic [7:0] step_x(input logic [1:0] d);
    case (d)
      2'b01:   step_x = 8'd1;
      2'b10:   step_x = 8'hFF;
      default: step_x = 8'd0;
    endcase
  endfunction

  function automatic logic [6:0] step_y(input logic [1:0] d);
    case (d)
      2'b01:   step_y = 7'd1;
      2'b10:   step_y = 7'h7F;
      default: step_y = 7'd0;
    endcase
  endfunction

  function automatic logic on_edge(input logic [7:0] x, input logic [6:0] y);
    on_edge = (x == 8'd0) || (x == XM) || (y == 7'd0) || (y == YM);
  endfunction

  state_t                 state_r;
  logic [CW-1:0]          tick_cnt_r;
  logic [IW-1:0]          idx_r;
  logic                   tick_pend_r;
  logic                   sweep_tick_r;
  logic                   fire_pend_r;
  logic                   kill_now_r;
  logic                   ack_pend_r;
  logic [NUM_BULLETS-1:0] kill_pend_r;
  logic [NUM_BULLETS-1:0] active_r;
  logic [7:0]             fire_x_r;
  logic [6:0]             fire_y_r;
  logic [1:0]             fire_dx_r;
  logic [1:0]             fire_dy_r;
  logic [7:0]             pos_x_r [NUM_BULLETS];
  logic [6:0]             pos_y_r [NUM_BULLETS];
  logic [1:0]             dx_r    [NUM_BULLETS];
  logic [1:0]             dy_r    [NUM_BULLETS];
  logic                   plot_r;
  logic [7:0]             plot_x_r;
  logic [6:0]             plot_y_r;
  logic [2:0]             plot_colour_r;
  logic                   fire_ack_r;
  logic                   fire_drop_r;

  logic                   tick_evt_s;
  logic                   transfer_s;
  logic                   last_s;
  logic                   free_found_s;
  logic [IW-1:0]          free_idx_s;
  logic                   spawn_bad_s;
  logic [7:0]             nx_s;
  logic [6:0]             ny_s;
  logic                   new_edge_s;

  // Movement divider: counts down and reloads, one step event per period
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_r <= CW'(TICK_DIV - 1);
    end else if (tick_cnt_r == {CW{1'b0}}) begin
      tick_cnt_r <= CW'(TICK_DIV - 1);
    end else begin
      tick_cnt_r <= tick_cnt_r - CW'(1);
    end
  end

  // Lowest free slot, spawn validity and the moved position of the current slot
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = {IW{1'b0}};
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      free_found_s = active_r[i] ? free_found_s : 1'b1;
      free_idx_s   = active_r[i] ? free_idx_s : IW'(i);
    end
    tick_evt_s  = (tick_cnt_r == {CW{1'b0}});
    transfer_s  = plot_r & plot_ready;
    last_s      = (idx_r == IW'(NUM_BULLETS - 1));
    spawn_bad_s = !free_found_s || ((fire_dx_r == 2'b00) && (fire_dy_r == 2'b00))
                  || on_edge(fire_x_r, fire_y_r);
    nx_s        = pos_x_r[idx_r] + step_x(dx_r[idx_r]);
    ny_s        = pos_y_r[idx_r] + step_y(dy_r[idx_r]);
    new_edge_s  = on_edge(nx_s, ny_s);
  end

  // Sequencer: request bookkeeping, slot state and the registered pixel port
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_IDLE;
      idx_r         <= {IW{1'b0}};
      tick_pend_r   <= 1'b0;
      sweep_tick_r  <= 1'b0;
      fire_pend_r   <= 1'b0;
      kill_now_r    <= 1'b0;
      ack_pend_r    <= 1'b0;
      kill_pend_r   <= {NUM_BULLETS{1'b0}};
      active_r      <= {NUM_BULLETS{1'b0}};
      fire_x_r      <= 8'd0;
      fire_y_r      <= 7'd0;
      fire_dx_r     <= 2'b00;
      fire_dy_r     <= 2'b00;
      plot_r        <= 1'b0;
      plot_x_r      <= 8'd0;
      plot_y_r      <= 7'd0;
      plot_colour_r <= 3'b000;
      fire_ack_r    <= 1'b0;
      fire_drop_r   <= 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        pos_x_r[i] <= 8'd0;
        pos_y_r[i] <= 7'd0;
        dx_r[i]    <= 2'b00;
        dy_r[i]    <= 2'b00;
      end
    end else begin
      fire_ack_r  <= 1'b0;
      fire_drop_r <= 1'b0;
      // A step arriving while one is already pending is simply absorbed.
      if (tick_evt_s) tick_pend_r <= 1'b1;
      // Hits on dead slots are ignored; live-slot hits stay pending until handled.
      kill_pend_r <= kill_pend_r | (hit & active_r);
      if (fire) begin
        if (fire_pend_r) begin
          fire_drop_r <= 1'b1;
        end else begin
          fire_pend_r <= 1'b1;
          fire_x_r    <= ship_x;
          fire_y_r    <= ship_y;
          fire_dx_r   <= eff_dir(dir_x);
          fire_dy_r   <= eff_dir(dir_y);
        end
      end
      case (state_r)
        S_IDLE: begin
          if (fire_pend_r) begin
            state_r <= S_ALLOC;
          end else if (tick_pend_r || (|kill_pend_r)) begin
            state_r      <= S_SCAN;
            idx_r        <= {IW{1'b0}};
            sweep_tick_r <= tick_pend_r;
          end
        end
        S_ALLOC: begin
          fire_pend_r <= 1'b0;
          if (spawn_bad_s) begin
            fire_drop_r <= 1'b1;
            state_r     <= S_IDLE;
          end else begin
            idx_r                   <= free_idx_s;
            active_r[free_idx_s]    <= 1'b1;
            kill_pend_r[free_idx_s] <= 1'b0;
            pos_x_r[free_idx_s]     <= fire_x_r;
            pos_y_r[free_idx_s]     <= fire_y_r;
            dx_r[free_idx_s]        <= fire_dx_r;
            dy_r[free_idx_s]        <= fire_dy_r;
            plot_r                  <= 1'b1;
            plot_x_r                <= fire_x_r;
            plot_y_r                <= fire_y_r;
            plot_colour_r           <= 3'b111;
            ack_pend_r              <= 1'b0;
            state_r                 <= S_SPAWN;
          end
        end
        S_SPAWN: begin
          // Acknowledge only one cycle after the spawn pixel has been accepted.
          if (transfer_s) begin
            plot_r     <= 1'b0;
            ack_pend_r <= 1'b1;
          end else if (ack_pend_r) begin
            fire_ack_r <= 1'b1;
            ack_pend_r <= 1'b0;
            state_r    <= S_IDLE;
          end
        end
        S_SCAN: begin
          if (active_r[idx_r] && (kill_pend_r[idx_r] || sweep_tick_r)) begin
            // Kill decision is frozen here; later hits wait for the next visit.
            kill_now_r    <= kill_pend_r[idx_r];
            plot_r        <= 1'b1;
            plot_x_r      <= pos_x_r[idx_r];
            plot_y_r      <= pos_y_r[idx_r];
            plot_colour_r <= 3'b000;
            state_r       <= S_ERASE;
          end else if (last_s) begin
            if (sweep_tick_r) tick_pend_r <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        S_ERASE: begin
          if (transfer_s) begin
            plot_r  <= 1'b0;
            state_r <= S_MOVE;
          end
        end
        S_MOVE: begin
          if (kill_now_r || !sweep_tick_r || new_edge_s) begin
            if (kill_now_r || (sweep_tick_r && new_edge_s)) begin
              active_r[idx_r]    <= 1'b0;
              kill_pend_r[idx_r] <= 1'b0;
            end
            if (last_s) begin
              if (sweep_tick_r) tick_pend_r <= 1'b0;
              state_r <= S_IDLE;
            end else begin
              idx_r   <= idx_r + IW'(1);
              state_r <= S_SCAN;
            end
          end else begin
            pos_x_r[idx_r] <= nx_s;
            pos_y_r[idx_r] <= ny_s;
            plot_r         <= 1'b1;
            plot_x_r       <= nx_s;
            plot_y_r       <= ny_s;
            plot_colour_r  <= 3'b111;
            state_r        <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (transfer_s) begin
            plot_r <= 1'b0;
            if (last_s) begin
              if (sweep_tick_r) tick_pend_r <= 1'b0;
              state_r <= S_IDLE;
            end else begin
              idx_r   <= idx_r + IW'(1);
              state_r <= S_SCAN;
            end
          end
        end
        default: begin
          plot_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign plot        = plot_r;
  assign plot_x      = plot_x_r;
  assign plot_y      = plot_y_r;
  assign plot_colour = plot_colour_r;
  assign active      = active_r;
  assign fire_ack    = fire_ack_r;
  assign fire_drop   = fire_drop_r;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler: spawn latency, stepping, pool full,
// boundary retire, hit kill, plot back-pressure and reset mid-sweep.
module tb_bullet_scheduler;

  localparam int NB = 4;
  localparam int TD = 200;

  logic          clk = 1'b0;
  logic          reset;
  logic          fire;
  logic [7:0]    ship_x;
  logic [6:0]    ship_y;
  logic [1:0]    dir_x;
  logic [1:0]    dir_y;
  logic [NB-1:0] hit;
  logic          plot_ready;
  logic          plot;
  logic [7:0]    plot_x;
  logic [6:0]    plot_y;
  logic [2:0]    plot_colour;
  logic [NB-1:0] active;
  logic          fire_ack;
  logic          fire_drop;

  int n_vec    = 0;
  int n_err    = 0;
  int ack_cnt  = 0;
  int drop_cnt = 0;
  int k;
  logic [17:0] xq[$];

  always #5 clk = ~clk;

  bullet_scheduler #(.NUM_BULLETS(NB), .TICK_DIV(TD), .X_MAX(159), .Y_MAX(119)) dut (
    .clk(clk), .reset(reset), .fire(fire), .ship_x(ship_x), .ship_y(ship_y),
    .dir_x(dir_x), .dir_y(dir_y), .hit(hit), .plot_ready(plot_ready),
    .plot(plot), .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
    .active(active), .fire_ack(fire_ack), .fire_drop(fire_drop)
  );

  // Record every accepted pixel and count ack/drop pulses
  always @(negedge clk) begin
    if (!reset) begin
      if (plot && plot_ready) xq.push_back({plot_x, plot_y, plot_colour});
      if (fire_ack) ack_cnt++;
      if (fire_drop) drop_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pix(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    pix = {14'd0, x, y, c};
  endfunction

  function automatic logic [31:0] qget(input int i);
    if (i < xq.size()) qget = {14'd0, xq[i]};
    else qget = 32'hFFFF_FFFF;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fire  = 1'b0;
    hit   = '0;
    step(2);
    reset = 1'b0;
    xq.delete();
    ack_cnt  = 0;
    drop_cnt = 0;
  endtask

  task automatic do_fire(input logic [7:0] x, input logic [6:0] y, input logic [1:0] dx, input logic [1:0] dy);
    fire   = 1'b1;
    ship_x = x;
    ship_y = y;
    dir_x  = dx;
    dir_y  = dy;
    step(1);
    fire   = 1'b0;
  endtask

  task automatic wait_q(input int n, input string tag);
    int c;
    c = 0;
    while (xq.size() < n && c < 500) begin
      step(1);
      c++;
    end
    check(tag, 32'(xq.size()), 32'(n));
  endtask

  initial begin
    reset = 1'b1; fire = 1'b0; ship_x = 8'd0; ship_y = 7'd0;
    dir_x = 2'b00; dir_y = 2'b00; hit = '0; plot_ready = 1'b1;
    @(posedge clk);
    #1;

    // 1: reset state, spawn latency and ack timing
    do_reset();
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_pix", pix(plot_x, plot_y, plot_colour), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_ack_drop", 32'({fire_ack, fire_drop}), 32'd0);
    do_fire(8'd80, 7'd60, 2'b01, 2'b00);
    check("t1_lat1", 32'(plot), 32'd0);
    step(1);
    check("t1_lat2", 32'(plot), 32'd0);
    step(1);
    check("t1_spawn_plot", 32'(plot), 32'd1);
    check("t1_spawn_pix", pix(plot_x, plot_y, plot_colour), pix(8'd80, 7'd60, 3'd7));
    step(1);
    check("t1_ack_early", 32'(fire_ack), 32'd0);
    step(1);
    check("t1_ack", 32'(fire_ack), 32'd1);
    step(1);
    check("t1_ack_pulse", 32'(fire_ack), 32'd0);
    check("t1_active", 32'(active), 32'h1);
    check("t1_q0", qget(0), pix(8'd80, 7'd60, 3'd7));

    // 2: each movement step erases the old pixel and draws one column right
    wait_q(3, "t2_len1");
    check("t2_erase1", qget(1), pix(8'd80, 7'd60, 3'd0));
    check("t2_draw1", qget(2), pix(8'd81, 7'd60, 3'd7));
    wait_q(5, "t2_len2");
    check("t2_erase2", qget(3), pix(8'd81, 7'd60, 3'd0));
    check("t2_draw2", qget(4), pix(8'd82, 7'd60, 3'd7));
    step(20);
    check("t2_quiet", 32'(xq.size()), 32'd5);
    check("t2_active", 32'(active), 32'h1);

    // 3: invalid spawns, fill the pool, overflow
    do_reset();
    do_fire(8'd50, 7'd50, 2'b11, 2'b11); step(7);
    do_fire(8'd0, 7'd50, 2'b01, 2'b00); step(7);
    do_fire(8'd50, 7'd119, 2'b01, 2'b01); step(7);
    check("t3_bad_drops", 32'(drop_cnt), 32'd3);
    check("t3_bad_noplot", 32'(xq.size()), 32'd0);
    check("t3_bad_active", 32'(active), 32'd0);
    do_fire(8'd20, 7'd20, 2'b01, 2'b00); step(7);
    do_fire(8'd30, 7'd30, 2'b10, 2'b00); step(7);
    do_fire(8'd40, 7'd40, 2'b00, 2'b01); step(7);
    do_fire(8'd50, 7'd50, 2'b00, 2'b10); step(7);
    check("t3_full", 32'(active), 32'hF);
    check("t3_acks", 32'(ack_cnt), 32'd4);
    check("t3_q3", qget(3), pix(8'd50, 7'd50, 3'd7));
    do_fire(8'd60, 7'd60, 2'b01, 2'b01); step(7);
    check("t3_overflow_drop", 32'(drop_cnt), 32'd4);
    check("t3_overflow_noplot", 32'(xq.size()), 32'd4);
    check("t3_overflow_acks", 32'(ack_cnt), 32'd4);

    // 4: step onto the right edge retires the slot without drawing
    do_reset();
    do_fire(8'd158, 7'd10, 2'b01, 2'b00); step(7);
    check("t4_active0", 32'(active), 32'h1);
    wait_q(2, "t4_len");
    step(5);
    check("t4_erase", qget(1), pix(8'd158, 7'd10, 3'd0));
    check("t4_retired", 32'(active), 32'd0);
    step(10);
    check("t4_nodraw", 32'(xq.size()), 32'd2);

    // 5: fire while busy, hit on live slot, hit on dead slot
    do_reset();
    fire = 1'b1; ship_x = 8'd20; ship_y = 7'd20; dir_x = 2'b01; dir_y = 2'b00;
    step(1);
    ship_x = 8'd40; ship_y = 7'd40; dir_x = 2'b00; dir_y = 2'b01;
    step(1);
    fire = 1'b0;
    check("t5_busy_drop", 32'(fire_drop), 32'd1);
    step(6);
    check("t5_first_only", 32'(active), 32'h1);
    check("t5_q0", qget(0), pix(8'd20, 7'd20, 3'd7));
    do_fire(8'd40, 7'd40, 2'b00, 2'b01); step(7);
    check("t5_two", 32'(active), 32'h3);
    hit = 4'b0010;
    step(1);
    hit = 4'b0000;
    wait_q(3, "t5_len");
    step(3);
    check("t5_kill_erase", qget(2), pix(8'd40, 7'd40, 3'd0));
    check("t5_killed", 32'(active), 32'h1);
    hit = 4'b0100;
    step(1);
    hit = 4'b0000;
    step(10);
    check("t5_dead_hit_noplot", 32'(xq.size()), 32'd3);
    check("t5_dead_hit_active", 32'(active), 32'h1);

    // 6: back-pressure during draw, then reset in the middle of a sweep
    do_reset();
    do_fire(8'd30, 7'd30, 2'b01, 2'b01); step(7);
    check("t6_ack", 32'(ack_cnt), 32'd1);
    k = 0;
    while (!(plot && plot_colour == 3'b111 && xq.size() >= 2) && k < 400) begin
      step(1);
      k++;
    end
    plot_ready = 1'b0;
    check("t6_draw_seen", 32'(plot), 32'd1);
    check("t6_erase", qget(1), pix(8'd30, 7'd30, 3'd0));
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("t6_hold", {13'd0, plot, plot_x, plot_y, plot_colour}, {13'd0, 1'b1, 8'd31, 7'd31, 3'd7});
    end
    plot_ready = 1'b1;
    step(3);
    check("t6_draw", qget(2), pix(8'd31, 7'd31, 3'd7));
    check("t6_released", 32'(plot), 32'd0);
    plot_ready = 1'b0;
    k = 0;
    while (!plot && k < 400) begin
      step(1);
      k++;
    end
    check("t6_stall_erase", {13'd0, plot, plot_x, plot_y, plot_colour}, {13'd0, 1'b1, 8'd31, 7'd31, 3'd0});
    reset = 1'b1;
    step(1);
    check("t6_rst_plot", 32'(plot), 32'd0);
    check("t6_rst_pix", pix(plot_x, plot_y, plot_colour), 32'd0);
    check("t6_rst_active", 32'(active), 32'd0);
    check("t6_rst_ack_drop", 32'({fire_ack, fire_drop}), 32'd0);
    reset = 1'b0;
    plot_ready = 1'b1;
    step(20);
    check("t6_post_rst_quiet", 32'(xq.size()), 32'd3);
    check("t6_post_rst_active", 32'(active), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
